// File: rtl/cookie_pkg.sv
// Shared definitions for the cookie array sequencer: FSM state encoding and
// the array strobe modes (en/run/display combinations) driven onto the array.
package cookie_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_SNAP = 3'd3,
        ST_DUMP = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Array strobe bundle; run and display are mutually exclusive.
    typedef struct packed {
        logic en;
        logic run;
        logic display;
    } strobe_t;

    localparam strobe_t STROBE_OFF   = '{en: 1'b0, run: 1'b0, display: 1'b0};
    localparam strobe_t STROBE_SHIFT = '{en: 1'b1, run: 1'b0, display: 1'b0};
    localparam strobe_t STROBE_GEN   = '{en: 1'b1, run: 1'b1, display: 1'b0};
    localparam strobe_t STROBE_SNAP  = '{en: 1'b1, run: 1'b0, display: 1'b1};

endpackage

// File: rtl/cookie_seq_counter.sv
// Loadable up-counter with terminal-count flag.
// Ports:
//   clk, rst_n   clock, async active-low reset (count clears to 0)
//   load_i       load load_val_i (has priority over inc_i)
//   load_val_i   value loaded on load_i
//   inc_i        increment by one
//   term_i       terminal value compared against the current count
//   tc_o         count equals term_i
module cookie_seq_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/cookie_sequencer.sv
// Control FSM for a serially chained cookie (Game-of-Life cell) array.
// Per job: optionally shift a seed into the state chain, run gens generations,
// snapshot into the display chain, stream the display chain out, pulse done.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   start, start_load, gens            job request (sampled in IDLE only)
//   abort                              drop the current job, back to IDLE
//   load_valid, load_bit, load_ready   seed stream in
//   dump_valid, dump_bit, dump_last,
//   dump_ready                         display stream out
//   busy, done                         job status
//   cell_en, cell_run, cell_display    array strobes
//   cell_shift_in, disp_shift_in       chain heads
//   cell_shift_out, disp_shift_out     chain tails
module cookie_sequencer
    import cookie_pkg::*;
#(
    parameter int unsigned N_CELLS = 64,
    parameter int unsigned GEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_load,
    input  logic [GEN_W-1:0] gens,
    input  logic             abort,
    input  logic             load_valid,
    input  logic             load_bit,
    output logic             load_ready,
    output logic             dump_valid,
    output logic             dump_bit,
    output logic             dump_last,
    input  logic             dump_ready,
    output logic             busy,
    output logic             done,
    output logic             cell_en,
    output logic             cell_run,
    output logic             cell_display,
    output logic             cell_shift_in,
    output logic             disp_shift_in,
    input  logic             cell_shift_out,
    input  logic             disp_shift_out
);

    localparam int unsigned CNT_W = $clog2(N_CELLS + 1);

    state_e           state_q, state_d;
    logic [GEN_W-1:0] gens_q, gens_d;
    logic             cnt_clr, cnt_inc, cnt_tc;
    logic             gen_inc, gen_tc;
    logic             abort_act;
    strobe_t          strb;

    assign abort_act = abort && (state_q != ST_IDLE);

    // Next-state logic and counter control.
    always_comb begin
        state_d = state_q;
        gens_d  = gens_q;
        cnt_inc = 1'b0;
        gen_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    gens_d = gens;
                    if (start_load)        state_d = ST_LOAD;
                    else if (gens == '0)   state_d = ST_SNAP;
                    else                   state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    cnt_inc = 1'b1;
                    if (cnt_tc) state_d = (gens_q == '0) ? ST_SNAP : ST_RUN;
                end
            end
            ST_RUN: begin
                gen_inc = 1'b1;
                if (gen_tc) state_d = ST_SNAP;
            end
            ST_SNAP: state_d = ST_DUMP;
            ST_DUMP: begin
                if (dump_ready) begin
                    cnt_inc = 1'b1;
                    if (cnt_tc) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over any same-cycle transfer, which is then not counted.
        if (abort_act) begin
            state_d = ST_IDLE;
            cnt_inc = 1'b0;
            gen_inc = 1'b0;
        end
    end

    // Both counters restart from zero on every state change.
    assign cnt_clr = (state_d != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gens_q  <= '0;
        end else begin
            state_q <= state_d;
            gens_q  <= gens_d;
        end
    end

    cookie_seq_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_clr),
        .load_val_i ('0),
        .inc_i      (cnt_inc),
        .term_i     (CNT_W'(N_CELLS - 1)),
        .tc_o       (cnt_tc)
    );

    // RUN is only entered with gens_q >= 1, so gens_q-1 never underflows there.
    cookie_seq_counter #(.W(GEN_W)) u_gen_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_clr),
        .load_val_i ('0),
        .inc_i      (gen_inc),
        .term_i     (gens_q - GEN_W'(1)),
        .tc_o       (gen_tc)
    );

    // Output decode; in LOAD/DUMP the shift enable follows the handshake directly.
    always_comb begin
        strb          = STROBE_OFF;
        load_ready    = 1'b0;
        dump_valid    = 1'b0;
        dump_bit      = 1'b0;
        dump_last     = 1'b0;
        done          = 1'b0;
        cell_shift_in = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load_ready    = 1'b1;
                cell_shift_in = load_bit;
                if (load_valid) strb = STROBE_SHIFT;
            end
            ST_RUN:  strb = STROBE_GEN;
            ST_SNAP: strb = STROBE_SNAP;
            ST_DUMP: begin
                dump_valid    = 1'b1;
                dump_bit      = disp_shift_out;
                dump_last     = cnt_tc;
                // Ring the state chain so a full dump leaves it unchanged.
                cell_shift_in = cell_shift_out;
                if (dump_ready) strb = STROBE_SHIFT;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
        if (abort_act) begin
            strb          = STROBE_OFF;
            load_ready    = 1'b0;
            dump_valid    = 1'b0;
            dump_bit      = 1'b0;
            dump_last     = 1'b0;
            done          = 1'b0;
            cell_shift_in = 1'b0;
        end
    end

    assign cell_en       = strb.en;
    assign cell_run      = strb.run;
    assign cell_display  = strb.display;
    assign disp_shift_in = 1'b0;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cookie_sequencer.sv
// Bench for cookie_sequencer: emulates a 4-cell ring array (rule-150 generation
// step) around the DUT and predicts each job's dump from the seed pattern.
module tb_cookie_sequencer;

    localparam int unsigned N     = 4;
    localparam int unsigned GEN_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, start_load, abort;
    logic [GEN_W-1:0] gens;
    logic             load_valid, load_bit, load_ready;
    logic             dump_valid, dump_bit, dump_last, dump_ready;
    logic             busy, done;
    logic             cell_en, cell_run, cell_display, cell_shift_in, disp_shift_in;
    logic             cell_shift_out, disp_shift_out;

    cookie_sequencer #(.N_CELLS(N), .GEN_W(GEN_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_load     (start_load),
        .gens           (gens),
        .abort          (abort),
        .load_valid     (load_valid),
        .load_bit       (load_bit),
        .load_ready     (load_ready),
        .dump_valid     (dump_valid),
        .dump_bit       (dump_bit),
        .dump_last      (dump_last),
        .dump_ready     (dump_ready),
        .busy           (busy),
        .done           (done),
        .cell_en        (cell_en),
        .cell_run       (cell_run),
        .cell_display   (cell_display),
        .cell_shift_in  (cell_shift_in),
        .disp_shift_in  (disp_shift_in),
        .cell_shift_out (cell_shift_out),
        .disp_shift_out (disp_shift_out)
    );

    always #5 clk = ~clk;

    // One generation on a ring: each cell becomes left ^ self ^ right.
    function automatic logic [N-1:0] evolve(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[(i + N - 1) % N] ^ v[i] ^ v[(i + 1) % N];
        return r;
    endfunction

    // Pattern position k (k-th bit shifted in) sits at physical chain index N-1-k.
    function automatic logic [N-1:0] rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N - 1 - i];
        return r;
    endfunction

    // Array emulation: chain[0] is the head, chain[N-1] the tail.
    logic [N-1:0] chain, disp;
    always @(posedge clk) begin
        if (cell_en) begin
            if (cell_run)          chain <= evolve(chain);
            else if (cell_display) disp  <= chain;
            else begin
                chain <= {chain[N-2:0], cell_shift_in};
                disp  <= {disp[N-2:0], disp_shift_in};
            end
        end
    end
    assign cell_shift_out = chain[N-1];
    assign disp_shift_out = disp[N-1];

    int n_run = 0, n_disp = 0, n_done = 0, n_conflict = 0;
    always @(posedge clk) begin
        if (cell_en && cell_run)     n_run      <= n_run + 1;
        if (cell_en && cell_display) n_disp     <= n_disp + 1;
        if (cell_run && cell_display) n_conflict <= n_conflict + 1;
        if (done)                    n_done     <= n_done + 1;
    end

    int n_checks = 0, n_pass = 0, n_fail = 0;
    logic [N-1:0] ref_pat;  // expected logical state-chain contents

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] all_outs();
        return {load_ready, dump_valid, dump_bit, dump_last, busy, done,
                cell_en, cell_run, cell_display, cell_shift_in, disp_shift_in};
    endfunction

    // Full job; called just after a falling edge with the DUT idle.
    // seed[k] is the k-th bit shifted in. vmode: 0 continuous, 1 toggling, 2 random valid.
    task automatic do_job(input bit ld, input logic [N-1:0] seed, input int g, input int vmode,
                          input int stall_at, input int stall_len, input bit poke);
        logic [N-1:0] exp_pat;
        int k, j, it, run0, disp0, done0;
        run0 = n_run; disp0 = n_disp; done0 = n_done;
        start = 1'b1; start_load = ld; gens = GEN_W'(g);
        #1;
        check("idle_before_start", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        if (ld) begin
            k = 0; it = 0;
            while (k < N && it < 64) begin
                case (vmode)
                    0:       load_valid = 1'b1;
                    1:       load_valid = (it % 2 == 0);
                    default: load_valid = 1'($urandom % 2);
                endcase
                load_bit = seed[k];
                if (poke && it == 1) begin
                    start = 1'b1; start_load = 1'b0; gens = GEN_W'(g + 1);
                end
                #1;
                check("load_ready", load_ready, 1'b1);
                check("load_cell_en", cell_en, load_valid);
                check("load_shift_in", cell_shift_in, load_bit);
                check("load_no_run", {cell_run, cell_display}, 2'b00);
                if (load_valid) k++;
                it++;
                @(negedge clk);
                start = 1'b0; load_valid = 1'b0;
            end
            if (k < N) check("load_timeout", 1'b0, 1'b1);
            ref_pat = seed;
            #1;
            check("load_landed", chain, rev(seed));
        end
        exp_pat = ref_pat;
        for (int i = 0; i < g; i++) begin
            #1;
            check("run_strobe", {cell_en, cell_run, cell_display}, 3'b110);
            exp_pat = evolve(exp_pat);
            @(negedge clk);
        end
        #1;
        check("snap_strobe", {cell_en, cell_run, cell_display}, 3'b101);
        @(negedge clk);
        j = 0; it = 0;
        while (j < N && it < 64) begin
            dump_ready = !(it >= stall_at && it < stall_at + stall_len);
            #1;
            check("dump_valid", dump_valid, 1'b1);
            check("dump_bit", dump_bit, exp_pat[j]);
            check("dump_last", dump_last, (j == N - 1));
            check("dump_cell_en", cell_en, dump_ready);
            if (dump_ready) j++;
            it++;
            @(negedge clk);
            dump_ready = 1'b0;
        end
        if (j < N) check("dump_timeout", 1'b0, 1'b1);
        #1;
        check("done_pulse", {done, busy, cell_en}, 3'b110);
        @(negedge clk);
        #1;
        check("idle_after_done", {done, busy}, 2'b00);
        ref_pat = exp_pat;
        check("ring_restored", chain, rev(ref_pat));
        check("gen_count", n_run - run0, g);
        check("snap_count", n_disp - disp0, 1);
        check("done_count", n_done - done0, 1);
        check("run_display_excl", n_conflict, 0);
    endtask

    initial begin
        int run0, done0;
        rst_n = 1'b0; start = 1'b0; start_load = 1'b0; gens = '0; abort = 1'b0;
        load_valid = 1'b0; load_bit = 1'b0; dump_ready = 1'b0;
        #2;
        check("reset_outputs", all_outs(), 11'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Seed 1,0,1,1 (first bit shifted in first), no generations.
        @(negedge clk);
        do_job(1'b1, 4'b1101, 0, 0, 100, 0, 1'b0);

        // Evolve current state three generations, no load.
        @(negedge clk);
        do_job(1'b0, '0, 3, 0, 100, 0, 1'b0);

        // Toggling load_valid.
        @(negedge clk);
        do_job(1'b1, 4'($urandom), $urandom_range(1, 3), 1, 100, 0, 1'b0);

        // dump_ready low for 5 cycles mid-dump, random valid.
        @(negedge clk);
        do_job(1'b1, 4'($urandom), $urandom_range(0, 4), 2, 2, 5, 1'b0);

        // Abort in RUN after one generation; restart straight away.
        @(negedge clk);
        run0 = n_run; done0 = n_done;
        start = 1'b1; start_load = 1'b0; gens = 4'd3;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("abort_pre_run", cell_run, 1'b1);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_strobes", {cell_en, cell_run, cell_display, load_ready, dump_valid, done}, 6'd0);
        check("abort_busy_hold", busy, 1'b1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_idle", {busy, done}, 2'b00);
        check("abort_gens_run", n_run - run0, 1);
        check("abort_no_done", n_done - done0, 0);
        ref_pat = evolve(ref_pat);
        do_job(1'b0, '0, 1, 0, 100, 0, 1'b0);

        // Reset asserted during DUMP.
        @(negedge clk);
        start = 1'b1; start_load = 1'b0; gens = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        dump_ready = 1'b1;
        #1;
        check("pre_reset_dump", dump_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 11'd0);
        @(negedge clk);
        rst_n = 1'b1; dump_ready = 1'b0;

        // Max gens, with a start pulse during LOAD that must be ignored.
        @(negedge clk);
        do_job(1'b1, 4'($urandom), 15, 0, 100, 0, 1'b1);

        // Random jobs.
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            do_job(1'($urandom % 2), 4'($urandom), $urandom_range(0, 6), $urandom_range(0, 2),
                   $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
